// File: rtl/sweep_checker.sv
// sweep_checker: receive-side verifier for the sawtooth DAC test sweep.
// It checks each valid sample against the expected ramp and acquires lock.
// It also counts errors and measures the sweep period in valid samples.
module sweep_checker #(
  parameter int unsigned MAX_DELTA  = 1,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             on_in,
  input  logic             clear_in,
  input  logic [15:0]      minval_in,
  input  logic [15:0]      maxval_in,
  input  logic [15:0]      data_in,
  input  logic             valid_in,
  output logic             locked_out,
  output logic             err_out,
  output logic             wrap_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [31:0]      period_out
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;

  localparam logic signed [16:0] MAXD_S    = 17'(MAX_DELTA);
  localparam logic [15:0]        LOCK_LAST = 16'(LOCK_COUNT - 1);

  state_t             state_q, state_d;
  logic [15:0]        prev_q, prev_d;
  logic               prev_ok_q, prev_ok_d;
  logic [15:0]        good_cnt_q, good_cnt_d;
  logic [31:0]        period_cnt_q, period_cnt_d;
  logic [31:0]        period_q, period_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;
  logic               locked_q, locked_d;

  // Sample classification, sign-extended to 17 bits so full-scale ranges cannot overflow
  logic signed [16:0] data_x, prev_x, min_x, max_x, delta, wrap_thr;
  logic               wrap_hit, step_ok, sample_good, lock_hit;

  always_comb begin
    data_x      = {data_in[15], data_in};
    prev_x      = {prev_q[15], prev_q};
    min_x       = {minval_in[15], minval_in};
    max_x       = {maxval_in[15], maxval_in};
    delta       = data_x - prev_x;
    wrap_thr    = max_x - MAXD_S;
    wrap_hit    = (data_x == min_x) && (prev_x >= wrap_thr);
    step_ok     = (delta >= 17'sd0) && (delta <= MAXD_S) && (data_x <= max_x);
    sample_good = wrap_hit || step_ok;
    lock_hit    = (good_cnt_q == LOCK_LAST);
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: enable low beats clear, clear beats sample processing
  always_comb begin
    state_d = state_q;
    if (!on_in) begin
      state_d = IDLE;
    end else if (clear_in) begin
      state_d = ACQUIRE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (valid_in && prev_ok_q && wrap_hit) state_d = TRACK;
        TRACK: begin
          if (valid_in) begin
            if (!sample_good)  state_d = ACQUIRE;
            else if (lock_hit) state_d = LOCKED;
          end
        end
        LOCKED:  if (valid_in && !sample_good) state_d = ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the datapath registers and registered outputs
  always_comb begin
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    good_cnt_d   = good_cnt_q;
    period_cnt_d = period_cnt_q;
    period_d     = period_q;
    err_cnt_d    = err_cnt_q;
    err_d        = 1'b0;
    wrap_d       = 1'b0;
    locked_d     = (state_d == LOCKED);
    // Clear zeroes statistics even while disabled; only the state choice differs
    if (clear_in) begin
      err_cnt_d    = '0;
      period_d     = '0;
      period_cnt_d = '0;
      good_cnt_d   = '0;
      prev_ok_d    = 1'b0;
    end
    if (!on_in) begin
      prev_ok_d = 1'b0;
    end else if (!clear_in && valid_in) begin
      case (state_q)
        ACQUIRE: begin
          prev_d    = data_in;
          prev_ok_d = 1'b1;
          if (prev_ok_q && wrap_hit) begin
            good_cnt_d   = '0;
            period_cnt_d = 32'd1;
          end
        end
        TRACK, LOCKED: begin
          prev_d = data_in;
          if (sample_good) begin
            if (good_cnt_q != '1) good_cnt_d = good_cnt_q + 16'd1;
            if (wrap_hit) begin
              period_d     = period_cnt_q;
              period_cnt_d = 32'd1;
              wrap_d       = 1'b1;
            end else if (period_cnt_q != '1) begin
              period_cnt_d = period_cnt_q + 32'd1;
            end
          end else begin
            err_d     = 1'b1;
            prev_ok_d = 1'b0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      good_cnt_q   <= '0;
      period_cnt_q <= '0;
      period_q     <= '0;
      err_cnt_q    <= '0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      good_cnt_q   <= good_cnt_d;
      period_cnt_q <= period_cnt_d;
      period_q     <= period_d;
      err_cnt_q    <= err_cnt_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      locked_q     <= locked_d;
    end
  end

  assign locked_out    = locked_q;
  assign err_out       = err_q;
  assign wrap_out      = wrap_q;
  assign err_count_out = err_cnt_q;
  assign period_out    = period_q;

endmodule

// File: tb/tb_sweep_checker.sv
// tb_sweep_checker: directed sweeps against a behavioural ramp model.
module tb_sweep_checker;

  localparam int MAXD = 1;
  localparam int LC   = 16;
  localparam int EW   = 4;
  localparam longint MAXU32 = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_in, on_in, clear_in, valid_in;
  logic [15:0]   minval_in, maxval_in, data_in;
  logic          locked_out, err_out, wrap_out;
  logic [EW-1:0] err_count_out;
  logic [31:0]   period_out;

  always #5 clk = ~clk;

  sweep_checker #(.MAX_DELTA(MAXD), .LOCK_COUNT(LC), .ERR_W(EW)) dut (
    .clk_in(clk), .rst_in(rst_in), .on_in(on_in), .clear_in(clear_in),
    .minval_in(minval_in), .maxval_in(maxval_in), .data_in(data_in),
    .valid_in(valid_in), .locked_out(locked_out), .err_out(err_out),
    .wrap_out(wrap_out), .err_count_out(err_count_out), .period_out(period_out)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: "tracking" means a wrap was seen with a known previous
  // sample; lock is simply a run of LC good samples since tracking began.
  bit     m_active, m_have_prev, m_tracking, m_locked, m_err_p, m_wrap_p;
  int     m_prev, m_run, m_errs;
  longint m_since, m_period;

  initial begin
    m_active = 0; m_have_prev = 0; m_tracking = 0; m_locked = 0;
    m_err_p = 0; m_wrap_p = 0; m_prev = 0; m_run = 0; m_errs = 0;
    m_since = 0; m_period = 0;
  end

  always @(posedge clk) begin : model
    int d, mn, mx;
    bit w, ok;
    d  = $signed(data_in);
    mn = $signed(minval_in);
    mx = $signed(maxval_in);
    m_err_p = 0;
    m_wrap_p = 0;
    if (rst_in) begin
      m_active = 0; m_have_prev = 0; m_tracking = 0; m_locked = 0;
      m_prev = 0; m_run = 0; m_errs = 0; m_since = 0; m_period = 0;
    end else if (!on_in) begin
      m_active = 0; m_have_prev = 0; m_tracking = 0; m_locked = 0;
      if (clear_in) begin m_errs = 0; m_period = 0; m_since = 0; m_run = 0; end
    end else if (clear_in) begin
      m_errs = 0; m_period = 0; m_since = 0; m_run = 0;
      m_have_prev = 0; m_tracking = 0; m_locked = 0; m_active = 1;
    end else if (!m_active) begin
      m_active = 1;
    end else if (valid_in) begin
      w = (d == mn) && (m_prev >= mx - MAXD);
      if (!m_tracking) begin
        if (m_have_prev && w) begin m_tracking = 1; m_run = 0; m_since = 1; end
        m_have_prev = 1;
      end else begin
        ok = w || ((d - m_prev) >= 0 && (d - m_prev) <= MAXD && d <= mx);
        if (ok) begin
          m_run++;
          if (m_run >= LC) m_locked = 1;
          if (w) begin m_period = m_since; m_since = 1; m_wrap_p = 1; end
          else if (m_since < MAXU32) m_since++;
        end else begin
          m_err_p = 1;
          if (m_errs < (1 << EW) - 1) m_errs++;
          m_tracking = 0; m_locked = 0; m_have_prev = 0;
        end
      end
      m_prev = d;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("locked", locked_out, m_locked);
    chk("err", err_out, m_err_p);
    chk("wrap", wrap_out, m_wrap_p);
    chk("err_count", err_count_out, m_errs);
    chk("period", period_out, m_period);
  end

  task automatic drive(input bit v, input int d);
    valid_in = v;
    data_in  = d[15:0];
    @(negedge clk);
  endtask

  function automatic int rv(input int k);
    return -4 + (k / 2) % 8;
  endfunction

  initial begin
    rst_in = 1; on_in = 0; clear_in = 0; valid_in = 0; data_in = '0;
    minval_in = 16'hFFFC; maxval_in = 16'd3;
    @(negedge clk);
    drive(0, 0);
    chk("lit_rst_locked", locked_out, 0);
    chk("lit_rst_err", err_out, 0);
    chk("lit_rst_wrap", wrap_out, 0);
    chk("lit_rst_errcnt", err_count_out, 0);
    chk("lit_rst_period", period_out, 0);

    // Ideal sweep with occasional gaps
    rst_in = 0; on_in = 1;
    drive(0, 0);
    for (int k = 8; k <= 32; k++) begin
      drive(1, rv(k));
      if (k % 5 == 0) drive(0, 99);
    end
    chk("lit_ideal_locked", locked_out, 1);
    chk("lit_ideal_wrap", wrap_out, 1);
    chk("lit_ideal_period", period_out, 16);
    chk("lit_ideal_errcnt", err_count_out, 0);

    // Glitch while locked
    for (int k = 33; k <= 41; k++) drive(1, rv(k));
    drive(1, 3);
    chk("lit_glitch_err", err_out, 1);
    chk("lit_glitch_errcnt", err_count_out, 1);
    chk("lit_glitch_locked", locked_out, 0);
    for (int k = 43; k <= 63; k++) drive(1, rv(k));
    chk("lit_relock_early", locked_out, 0);
    drive(1, rv(64));
    chk("lit_relock", locked_out, 1);
    chk("lit_relock_period", period_out, 16);

    // Repeated backward steps drive the error counter into saturation
    for (int it = 0; it < 16; it++) begin
      for (int v = -4; v <= 2; v++) drive(1, v);
      drive(1, 1);
      if (it == 0) begin
        chk("lit_back_errcnt", err_count_out, 2);
        chk("lit_back_locked", locked_out, 0);
      end
      if (it == 13) chk("lit_sat_reach", err_count_out, 15);
      if (it == 15) begin
        chk("lit_sat_err", err_out, 1);
        chk("lit_sat_hold", err_count_out, 15);
      end
      drive(1, 2);
      drive(1, 3);
    end

    // Clear coinciding with a would-be wrap sample
    clear_in = 1;
    drive(1, -4);
    clear_in = 0;
    chk("lit_clr_errcnt", err_count_out, 0);
    chk("lit_clr_period", period_out, 0);
    chk("lit_clr_locked", locked_out, 0);
    chk("lit_clr_wrap", wrap_out, 0);
    for (int k = 2; k <= 32; k++) drive(1, rv(k));
    chk("lit_clr_relock", locked_out, 1);
    chk("lit_clr_period2", period_out, 16);

    // Reset mid-sweep while locked
    for (int k = 33; k <= 36; k++) drive(1, rv(k));
    rst_in = 1;
    drive(1, rv(37));
    rst_in = 0;
    chk("lit_mrst_locked", locked_out, 0);
    chk("lit_mrst_err", err_out, 0);
    chk("lit_mrst_wrap", wrap_out, 0);
    chk("lit_mrst_errcnt", err_count_out, 0);
    chk("lit_mrst_period", period_out, 0);
    for (int k = 38; k <= 64; k++) drive(1, rv(k));
    chk("lit_mrst_relock", locked_out, 1);
    chk("lit_mrst_period2", period_out, 16);

    // Disable holds statistics but drops lock
    on_in = 0;
    drive(1, rv(65));
    drive(1, rv(66));
    chk("lit_off_locked", locked_out, 0);
    chk("lit_off_period", period_out, 16);

    // Full-scale sweep
    minval_in = 16'h8000; maxval_in = 16'h7FFF;
    on_in = 1;
    drive(0, 0);
    for (int v = 32760; v <= 32767; v++) drive(1, v);
    drive(1, -32768);
    for (int v = -32767; v <= 32767; v++) drive(1, v);
    drive(1, -32768);
    chk("lit_fs_period", period_out, 65536);
    chk("lit_fs_wrap", wrap_out, 1);
    chk("lit_fs_errcnt", err_count_out, 0);
    chk("lit_fs_locked", locked_out, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
